sklansky_mp_add_seq: RTL and testbench
======================================

Name: sklansky_mp_add_seq

Overview:
- Multi-precision add/subtract sequencer. Reuses one WIDTH-bit Sklansky_adder slice over NWORDS cycles to form a WIDTH*NWORDS-bit result.
- Carry is held in a register between slices.
- Operand and result transfer use valid/ready handshakes, so one adder serves wide-word arithmetic (e.g. 256-bit crypto/bignum paths) at reduced area.

Parameters:
- WIDTH, 64, slice width passed to the Sklansky_adder instance; must be a multiple of 16.
- NWORDS, 4, number of slices per operation; must be >= 2. Total operand width is TW = WIDTH*NWORDS.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand request.
- in_ready  output  1  block can accept an operand request.
- in_a  input  TW  operand A.
- in_b  input  TW  operand B.
- in_cin  input  1  carry-in; acts as borrow-in when in_sub=1.
- in_sub  input  1  0: A+B+cin; 1: A-B-cin.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_sum  output  TW  result, modulo 2^TW.
- out_cout  output  1  final carry out; for subtract, 1 means no borrow.
- out_zero  output  1  out_sum == 0.
- busy  output  1  state != IDLE.

Behaviour:
- Reset is asynchronous and active-high. One clock domain (clk).
- While rst=1: state=IDLE, idx=0, carry=0, result register=0, out_valid=0, out_cout=0, out_zero=0, busy=0, in_ready=0.
- FSM states are IDLE, RUN and DONE.
- IDLE: in_ready=1 (gated low by rst).
  - On in_valid&in_ready at edge E0: capture in_a.
  - Capture in_b XOR {TW{in_sub}}.
  - Load carry <= in_cin XOR in_sub, idx <= 0, state <= RUN.
- RUN: in_ready=0. A single Sklansky_adder #(WIDTH) instance is fed slice idx of the captured A and B, with cin = carry.
  - At each edge, result slice idx <= sum and carry <= cout.
  - If idx == NWORDS-1, state <= DONE; otherwise idx <= idx+1.
  - Slices are processed LSW first.
- DONE: out_valid=1. out_sum = result register, out_cout = carry, out_zero = (result == 0).
  - All outputs hold stable while out_ready=0.
  - On out_valid&out_ready: state <= IDLE. out_valid drops after that edge.
- Latency: out_valid rises immediately after edge E0+NWORDS.
- Throughput: with in_valid and out_ready held high, one operation per NWORDS+2 edges. The next accept occurs at E0+NWORDS+2.
- No in_valid/out_ready combinational path to in_ready in the same cycle. The block does not accept new input in DONE, even if out_ready=1.
- Operands are sampled only at the accept edge. Later changes on in_a/in_b/in_cin/in_sub have no effect.
- out_sum/out_cout/out_zero are don't-care when out_valid=0. They are held from the last result; the bench checks them only with out_valid=1.
- idx is ceil(log2(NWORDS)) bits wide (min 1). No wrap occurs because the RUN exit happens at NWORDS-1.
- Reset mid-RUN or mid-DONE aborts the operation. No partial result is emitted. After rst deasserts, the block is in IDLE with in_ready=1.
- in_valid asserted during reset is ignored.

Test Plan:
- Full-carry ripple (WIDTH=64, NWORDS=4): a=2^256-1, b=1, cin=0, sub=0 -> out_sum=0, out_cout=1, out_zero=1. out_valid rises exactly 4 edges after accept.
- Subtract with cross-slice borrow: a=2^64, b=1, cin=0, sub=1 -> out_sum=0x0000..0000_FFFFFFFFFFFFFFFF, out_cout=1, out_zero=0.
- Underflow: a=0, b=1, sub=1 -> out_sum=2^256-1, out_cout=0. Then a=5, b=3, sub=1, cin=1 -> out_sum=1, out_cout=1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_sum/out_cout stable, in_ready=0, and an asserted in_valid is not accepted. Raise out_ready -> IDLE next edge, accept on the following edge.
- Back-to-back: in_valid=1, out_ready=1, three random operation pairs -> results match a reference model. Accept edges are spaced 6 apart.
- Reset abort: assert rst while idx=2 in RUN -> out_valid=0, busy=0, in_ready=0 immediately (async). After release, a=7, b=9, add -> out_sum=16 with no residue from the aborted operation.

Source files
------------

// File: rtl/sklansky_mp_add_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : sklansky_mp_add_seq_if
// Description : Operand/result handshake bundle for sklansky_mp_add_seq.
//               Operand side: in_valid/in_ready, in_a, in_b, in_cin, in_sub.
//               Result side : out_valid/out_ready, out_sum, out_cout, out_zero.
//               master = producer/consumer (bench), slave = the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface sklansky_mp_add_seq_if #(
  parameter int WIDTH  = 64,
  parameter int NWORDS = 4
);
  localparam int TW = WIDTH * NWORDS;

  logic          in_valid;
  logic          in_ready;
  logic [TW-1:0] in_a;
  logic [TW-1:0] in_b;
  logic          in_cin;
  logic          in_sub;
  logic          out_valid;
  logic          out_ready;
  logic [TW-1:0] out_sum;
  logic          out_cout;
  logic          out_zero;

  modport master (
    output in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_zero
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, in_sub, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_zero
  );
endinterface
`default_nettype wire

// File: rtl/sklansky_mp_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : Sklansky_adder
// Description : WIDTH-bit parallel-prefix (Sklansky) adder with carry in/out.
//               Ports: a, b, cin -> sum, cout.
// Revision    : 1.0 - initial release
// ============================================================================
module Sklansky_adder #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int LEVELS = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] p_bit;
  logic [WIDTH-1:0] carry_in;

  always_comb begin
    p_bit = a ^ b;
    g     = a & b;
    p     = p_bit;
    // Fold carry-in into bit 0 so every prefix group starting at bit 0 is
    // a complete carry-out term.
    g[0]  = g[0] | (p[0] & cin);
    for (int l = 0; l < LEVELS; l++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (((i >> l) & 1) != 0) begin
          // j is the top bit of the neighbouring lower block; its own bit l
          // is clear so it is not rewritten at this level (in-place safe).
          g[i] = g[i] | (p[i] & g[((i >> l) << l) - 1]);
          p[i] = p[i] & p[((i >> l) << l) - 1];
        end
      end
    end
    carry_in = {g[WIDTH-2:0], cin};
    sum      = p_bit ^ carry_in;
    cout     = g[WIDTH-1];
  end
endmodule

// ============================================================================
// Module      : sklansky_mp_add_seq
// Description : Multi-precision add/subtract sequencer. One WIDTH-bit Sklansky
//               slice is reused over NWORDS cycles (LSW first) with the carry
//               held in a register, giving a WIDTH*NWORDS-bit result.
//               Ports: clk, rst (async, active-high), bus (slave modport of
//               sklansky_mp_add_seq_if), busy (state != IDLE).
// Revision    : 1.0 - initial release
// ============================================================================
module sklansky_mp_add_seq #(
  parameter int WIDTH  = 64,
  parameter int NWORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  sklansky_mp_add_seq_if.slave  bus,
  output logic                  busy
);
  localparam int TW   = WIDTH * NWORDS;
  localparam int IDXW = (NWORDS > 2) ? $clog2(NWORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [TW-1:0]   a_q, a_d;
  logic [TW-1:0]   b_q, b_d;
  logic [TW-1:0]   res_q, res_d;

  logic [WIDTH-1:0] slice_a;
  logic [WIDTH-1:0] slice_b;
  logic [WIDTH-1:0] slice_sum;
  logic             slice_cout;

  assign slice_a = a_q[idx_q*WIDTH +: WIDTH];
  assign slice_b = b_q[idx_q*WIDTH +: WIDTH];

  Sklansky_adder #(.WIDTH(WIDTH)) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && bus.in_ready) begin
          // Subtract is A + ~B + ~borrow: invert B and the incoming carry.
          a_d     = bus.in_a;
          b_d     = bus.in_b ^ {TW{bus.in_sub}};
          carry_d = bus.in_cin ^ bus.in_sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d[idx_q*WIDTH +: WIDTH] = slice_sum;
        carry_d = slice_cout;
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // in_ready depends only on state and rst, never on in_valid/out_ready.
  assign bus.in_ready  = (state_q == IDLE) && !rst;
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_sum   = res_q;
  assign bus.out_cout  = carry_q;
  assign bus.out_zero  = (state_q == DONE) && (res_q == '0);
  assign busy          = (state_q != IDLE);
endmodule
`default_nettype wire

// File: tb/tb_sklansky_mp_add_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_sklansky_mp_add_seq
// Description : Self-checking bench for sklansky_mp_add_seq (WIDTH=64,
//               NWORDS=4) against a plain-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sklansky_mp_add_seq;
  localparam int WIDTH  = 64;
  localparam int NWORDS = 4;
  localparam int TW     = WIDTH * NWORDS;

  logic clk = 1'b0;
  logic rst;
  logic busy;
  int   n_tests = 0;
  int   n_fail  = 0;

  sklansky_mp_add_seq_if #(.WIDTH(WIDTH), .NWORDS(NWORDS)) bus ();

  sklansky_mp_add_seq #(.WIDTH(WIDTH), .NWORDS(NWORDS)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  // Reference: {carry/no-borrow, result mod 2^TW}.
  function automatic logic [TW:0] ref_op(input logic [TW-1:0] a, input logic [TW-1:0] b,
                                         input logic cin, input logic sub);
    logic [TW:0] r;
    if (!sub) begin
      r = {1'b0, a} + {1'b0, b} + (TW+1)'(cin);
    end else begin
      r[TW-1:0] = a - b - TW'(cin);
      r[TW]     = ({1'b0, a} >= ({1'b0, b} + (TW+1)'(cin)));
    end
    return r;
  endfunction

  function automatic logic [TW-1:0] rand_tw();
    logic [TW-1:0] r;
    for (int k = 0; k < TW/32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic start_op(input logic [TW-1:0] a, input logic [TW-1:0] b,
                          input logic cin, input logic sub, output bit ok);
    bus.in_a = a; bus.in_b = b; bus.in_cin = cin; bus.in_sub = sub;
    bus.in_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (bus.in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat, output bit ok);
    lat = 0; ok = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      if (bus.out_valid) ok = 1'b1;
      else begin @(posedge clk); #1; lat++; end
    end
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    bus.in_a = '1; bus.in_b = '1; bus.in_cin = 1'b1; bus.in_sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=0", bus.in_ready); end
    n_tests++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (bus.out_cout !== 1'b0) begin n_fail++; $display("FAIL reset_out_cout got=%b exp=0", bus.out_cout); end
    n_tests++; if (bus.out_zero !== 1'b0) begin n_fail++; $display("FAIL reset_out_zero got=%b exp=0", bus.out_zero); end
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_in_ready got=%b exp=1", bus.in_ready); end
    @(posedge clk); #1;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_no_accept busy got=%b exp=0", busy); end
  endtask

  // Runs one operation, checking latency and all result fields.
  task automatic test_op(input string name, input logic [TW-1:0] a, input logic [TW-1:0] b,
                         input logic cin, input logic sub);
    bit ok; int lat;
    logic [TW:0] exp;
    exp = ref_op(a, b, cin, sub);
    start_op(a, b, cin, sub, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL %s_accept timeout", name); end
    wait_out(lat, ok);
    n_tests++; if (!ok || lat != NWORDS) begin n_fail++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, NWORDS); end
    n_tests++; if (bus.out_sum !== exp[TW-1:0]) begin n_fail++; $display("FAIL %s_sum got=%h exp=%h", name, bus.out_sum, exp[TW-1:0]); end
    n_tests++; if (bus.out_cout !== exp[TW]) begin n_fail++; $display("FAIL %s_cout got=%b exp=%b", name, bus.out_cout, exp[TW]); end
    n_tests++; if (bus.out_zero !== (exp[TW-1:0] == '0)) begin n_fail++; $display("FAIL %s_zero got=%b exp=%b", name, bus.out_zero, (exp[TW-1:0] == '0)); end
    drain();
  endtask

  task automatic test_corner_cases();
    logic [TW-1:0] all_ones, two64;
    all_ones = '1;
    two64 = '0; two64[64] = 1'b1;
    test_op("ripple", all_ones, TW'(1), 1'b0, 1'b0);
    test_op("sub_borrow", two64, TW'(1), 1'b0, 1'b1);
    test_op("underflow", '0, TW'(1), 1'b0, 1'b1);
    test_op("sub_cin", TW'(5), TW'(3), 1'b1, 1'b1);
    for (int k = 0; k < 4; k++) test_op("random", rand_tw(), rand_tw(), 1'($urandom), 1'($urandom));
  endtask

  task automatic test_backpressure();
    bit ok; int lat;
    logic [TW-1:0] a, b, c, d;
    logic [TW:0] exp1, exp2;
    a = rand_tw(); b = rand_tw(); c = rand_tw(); d = rand_tw();
    exp1 = ref_op(a, b, 1'b0, 1'b0);
    exp2 = ref_op(c, d, 1'b1, 1'b1);
    start_op(a, b, 1'b0, 1'b0, ok);
    wait_out(lat, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL bp_done timeout"); end
    bus.in_a = c; bus.in_b = d; bus.in_cin = 1'b1; bus.in_sub = 1'b1; bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      n_tests++; if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_hold cyc=%0d valid=%b ready=%b exp 1/0", k, bus.out_valid, bus.in_ready); end
      n_tests++; if (bus.out_sum !== exp1[TW-1:0] || bus.out_cout !== exp1[TW]) begin n_fail++; $display("FAIL bp_stable cyc=%0d sum=%h cout=%b exp %h/%b", k, bus.out_sum, bus.out_cout, exp1[TW-1:0], exp1[TW]); end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    n_tests++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release valid=%b ready=%b exp 0/1", bus.out_valid, bus.in_ready); end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL bp_accept busy got=%b exp=1", busy); end
    wait_out(lat, ok);
    n_tests++; if (!ok || lat != NWORDS) begin n_fail++; $display("FAIL bp_latency got=%0d exp=%0d", lat, NWORDS); end
    n_tests++; if (bus.out_sum !== exp2[TW-1:0] || bus.out_cout !== exp2[TW]) begin n_fail++; $display("FAIL bp_second sum=%h cout=%b exp %h/%b", bus.out_sum, bus.out_cout, exp2[TW-1:0], exp2[TW]); end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [TW-1:0] oa [3];
    logic [TW-1:0] ob [3];
    logic          oc [3];
    logic          os [3];
    logic [TW:0]   exp [3];
    int sent, got, last_acc;
    bit acc, outv;
    logic [TW-1:0] s; logic c, z;
    for (int k = 0; k < 3; k++) begin
      oa[k] = rand_tw(); ob[k] = rand_tw(); oc[k] = 1'($urandom); os[k] = 1'($urandom);
      exp[k] = ref_op(oa[k], ob[k], oc[k], os[k]);
    end
    bus.out_ready = 1'b1;
    bus.in_a = oa[0]; bus.in_b = ob[0]; bus.in_cin = oc[0]; bus.in_sub = os[0]; bus.in_valid = 1'b1;
    sent = 1; got = 0; last_acc = -1;
    for (int k = 0; k < 60 && got < 3; k++) begin
      acc  = bus.in_valid && bus.in_ready;
      outv = bus.out_valid && bus.out_ready;
      s = bus.out_sum; c = bus.out_cout; z = bus.out_zero;
      @(posedge clk); #1;
      if (acc) begin
        if (last_acc >= 0) begin
          n_tests++; if (k - last_acc != NWORDS + 2) begin n_fail++; $display("FAIL b2b_spacing got=%0d exp=%0d", k - last_acc, NWORDS + 2); end
        end
        last_acc = k;
        if (sent < 3) begin
          bus.in_a = oa[sent]; bus.in_b = ob[sent]; bus.in_cin = oc[sent]; bus.in_sub = os[sent];
          sent++;
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (outv && got < 3) begin
        n_tests++; if (s !== exp[got][TW-1:0] || c !== exp[got][TW] || z !== (exp[got][TW-1:0] == '0)) begin
          n_fail++; $display("FAIL b2b_result op=%0d sum=%h cout=%b zero=%b exp %h/%b", got, s, c, z, exp[got][TW-1:0], exp[got][TW]);
        end
        got++;
      end
    end
    n_tests++; if (got != 3) begin n_fail++; $display("FAIL b2b_count got=%0d exp=3", got); end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    bit ok;
    start_op(rand_tw(), rand_tw(), 1'b1, 1'b0, ok);
    n_tests++; if (!ok) begin n_fail++; $display("FAIL abort_accept timeout"); end
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    n_tests++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL abort_async valid=%b busy=%b ready=%b exp 0/0/0", bus.out_valid, busy, bus.in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    n_tests++; if (bus.in_ready !== 1'b1) begin n_fail++; $display("FAIL abort_release ready got=%b exp=1", bus.in_ready); end
    @(posedge clk); #1;
    test_op("abort_after", TW'(7), TW'(9), 1'b0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_corner_cases();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
